// File: rtl/gate_mux_arbiter_pkg.sv
// Shared encodings and the round-robin owner choice for the gate_mux_arbiter block.
// The AND path serves requester A and the NAND path serves requester B.
package gate_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic SEL_AND  = 1'b0;
    localparam logic SEL_NAND = 1'b1;
    localparam logic OWNER_A  = 1'b0;
    localparam logic OWNER_B  = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_owner(input logic req_a, input logic req_b, input logic last);
        if (req_a && req_b) begin
            return (last == OWNER_A) ? OWNER_B : OWNER_A;
        end
        return req_a ? OWNER_A : OWNER_B;
    endfunction

    function automatic logic owner_to_select(input logic owner);
        return (owner == OWNER_B) ? SEL_NAND : SEL_AND;
    endfunction

endpackage

// File: rtl/gate_mux_datapath.sv
// Combinational AND/NAND pair with a 2:1 select, built entirely from NAND terms.
// Holds no state; the arbiter registers its operands, select and result.
module gate_mux_datapath #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic             select,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH-1:0] sel_v;
    logic [WIDTH-1:0] sel_n;
    logic [WIDTH-1:0] nand_xy;
    logic [WIDTH-1:0] and_xy;
    logic [WIDTH-1:0] pick_and_n;
    logic [WIDTH-1:0] pick_nand_n;

    assign sel_v       = {WIDTH{select}};
    assign sel_n       = ~(sel_v & sel_v);
    assign nand_xy     = ~(a_x & a_y);
    assign and_xy      = ~(nand_xy & nand_xy);
    // NAND-NAND mux: s = select ? nand_xy : and_xy
    assign pick_and_n  = ~(and_xy & sel_n);
    assign pick_nand_n = ~(nand_xy & sel_v);
    assign s           = ~(pick_and_n & pick_nand_n);

endmodule

// File: rtl/gate_mux_arbiter.sv
// Two-requester round-robin sequencer for the shared AND/NAND datapath:
// IDLE grants and captures operands, GRANT registers the result, DONE pulses the owner's ack.
module gate_mux_arbiter
    import gate_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] x_a,
    input  logic [WIDTH-1:0] y_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] x_b,
    input  logic [WIDTH-1:0] y_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] result,
    output logic             select,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             select_q, select_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] s;
    logic             grant_now;
    logic             next_owner;

    gate_mux_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a_x    (x_q),
        .a_y    (y_q),
        .select (select_q),
        .s      (s)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_A;
            last_q   <= OWNER_B;
            select_q <= SEL_AND;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            select_q <= select_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
        end
    end

    assign grant_now  = (state_q == ST_IDLE) && (req_a || req_b);
    assign next_owner = pick_owner(req_a, req_b, last_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_a || req_b) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand capture on grant; result capture at the end of GRANT. Everything else holds.
    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        select_d = select_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        if (grant_now) begin
            owner_d  = next_owner;
            last_d   = next_owner;
            select_d = owner_to_select(next_owner);
            x_d      = (next_owner == OWNER_B) ? x_b : x_a;
            y_d      = (next_owner == OWNER_B) ? y_b : y_a;
        end
        if (state_q == ST_GRANT) begin
            result_d = s;
        end
    end

    always_comb begin
        ack_a  = (state_q == ST_DONE) && (owner_q == OWNER_A);
        ack_b  = (state_q == ST_DONE) && (owner_q == OWNER_B);
        busy   = (state_q == ST_GRANT) || (state_q == ST_DONE);
        result = result_q;
        select = select_q;
    end

endmodule

// File: tb/tb_gate_mux_arbiter.sv
// Self-checking bench for gate_mux_arbiter: vector table over all operand combos on both paths,
// a scoreboard popped on every ack, plus hand-written round-robin, reset-abort and WIDTH=4 sequences.
module tb_gate_mux_arbiter;

    typedef struct {
        logic owner;
        logic x;
        logic y;
        logic exp_res;
    } vec_t;

    typedef struct {
        logic owner;
        logic res;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req_a, req_b;
    logic [0:0] x_a, y_a, x_b, y_b;
    logic       ack_a, ack_b, select, busy;
    logic [0:0] result;

    logic       req4_a, req4_b;
    logic [3:0] x4_a, y4_a, x4_b, y4_b;
    logic       ack4_a, ack4_b, select4, busy4;
    logic [3:0] result4;

    int   n_total;
    int   n_pass;
    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_ack;

    gate_mux_arbiter #(.WIDTH(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .x_a    (x_a),
        .y_a    (y_a),
        .req_b  (req_b),
        .x_b    (x_b),
        .y_b    (y_b),
        .ack_a  (ack_a),
        .ack_b  (ack_b),
        .result (result),
        .select (select),
        .busy   (busy)
    );

    gate_mux_arbiter #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req4_a),
        .x_a    (x4_a),
        .y_a    (y4_a),
        .req_b  (req4_b),
        .x_b    (x4_b),
        .y_b    (y4_b),
        .ack_a  (ack4_a),
        .ack_b  (ack4_b),
        .result (result4),
        .select (select4),
        .busy   (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the WIDTH=1 instance.
    initial prev_ack = 1'b0;
    always @(negedge clk) begin
        if (ack_a || ack_b) begin
            check("ack_exclusive", 32'(ack_a & ack_b), 0);
            check("ack_single_cycle", 32'(prev_ack), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_owner", 32'(ack_b), 32'(mon_e.owner));
                check("sb_result", 32'(result), 32'(mon_e.res));
            end
        end
        prev_ack = ack_a || ack_b;
    end

    // Entered at posedge+1 with the DUT in IDLE; leaves at posedge+1 back in IDLE.
    task automatic run_txn(input logic owner, input logic x, input logic y, input logic exp_res);
        int cycles;
        if (owner) begin
            req_b = 1'b1; x_b = x; y_b = y;
        end else begin
            req_a = 1'b1; x_a = x; y_a = y;
        end
        sb_q.push_back('{owner: owner, res: exp_res});
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("grant_busy", 32'(busy), 1);
        check("grant_select", 32'(select), 32'(owner));
        cycles = 2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cycles++;
            if ((owner ? ack_b : ack_a) === 1'b1) break;
        end
        check("ack_latency", 32'(cycles), 3);
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        check("after_busy", 32'(busy), 0);
        check("hold_select", 32'(select), 32'(owner));
        check("hold_result", 32'(result), 32'(exp_res));
    endtask

    initial begin
        vec_t vecs[8];
        int   acks;
        int   cycles;

        vecs[0] = '{owner: 1'b0, x: 1'b0, y: 1'b0, exp_res: 1'b0};
        vecs[1] = '{owner: 1'b0, x: 1'b0, y: 1'b1, exp_res: 1'b0};
        vecs[2] = '{owner: 1'b0, x: 1'b1, y: 1'b0, exp_res: 1'b0};
        vecs[3] = '{owner: 1'b0, x: 1'b1, y: 1'b1, exp_res: 1'b1};
        vecs[4] = '{owner: 1'b1, x: 1'b0, y: 1'b0, exp_res: 1'b1};
        vecs[5] = '{owner: 1'b1, x: 1'b0, y: 1'b1, exp_res: 1'b1};
        vecs[6] = '{owner: 1'b1, x: 1'b1, y: 1'b0, exp_res: 1'b1};
        vecs[7] = '{owner: 1'b1, x: 1'b1, y: 1'b1, exp_res: 1'b0};

        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        x_a = '0; y_a = '0; x_b = '0; y_b = '0;
        req4_a = 1'b0; req4_b = 1'b0;
        x4_a = '0; y4_a = '0; x4_b = '0; y4_b = '0;

        // 1: reset held for two cycles
        tick();
        tick();
        check("rst_ack_a", 32'(ack_a), 0);
        check("rst_ack_b", 32'(ack_b), 0);
        check("rst_result", 32'(result), 0);
        check("rst_select", 32'(select), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst4_result", 32'(result4), 0);
        reset = 1'b0;

        // 2 and 3: single requests on each path
        run_txn(1'b0, 1'b1, 1'b1, 1'b1);
        run_txn(1'b1, 1'b1, 1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b1);

        // All four operand combos on both paths
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].owner, vecs[i].x, vecs[i].y, vecs[i].exp_res);
        end

        // 4: both requests held from reset; grants must alternate A,B,A,B
        reset = 1'b1;
        tick();
        reset = 1'b0;
        x_a = 1'b1; y_a = 1'b1; x_b = 1'b1; y_b = 1'b1;
        sb_q.push_back('{owner: 1'b0, res: 1'b1});
        sb_q.push_back('{owner: 1'b1, res: 1'b0});
        sb_q.push_back('{owner: 1'b0, res: 1'b1});
        sb_q.push_back('{owner: 1'b1, res: 1'b0});
        req_a = 1'b1;
        req_b = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) acks++;
        end
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        check("rr_ack_count", 32'(acks), 4);
        check("rr_sb_drained", 32'(sb_q.size()), 0);

        // 5: reset during GRANT aborts the transaction
        run_txn(1'b1, 1'b0, 1'b0, 1'b1);
        req_a = 1'b1; x_a = 1'b1; y_a = 1'b1;
        tick();
        check("abort_grant_busy", 32'(busy), 1);
        reset = 1'b1;
        req_a = 1'b0;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_result", 32'(result), 0);
        check("abort_select", 32'(select), 0);
        check("abort_ack_a", 32'(ack_a), 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) acks++;
        end
        check("abort_no_ack", 32'(acks), 0);
        tick();

        // 6: WIDTH=4 on both paths
        req4_a = 1'b1; x4_a = 4'b1100; y4_a = 4'b1010;
        cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack4_a === 1'b1) begin
                cycles = i;
                break;
            end
        end
        check("w4_a_latency", 32'(cycles), 3);
        check("w4_a_result", 32'(result4), 32'(4'b1000));
        check("w4_a_ack_b", 32'(ack4_b), 0);
        tick();
        req4_a = 1'b0;

        req4_b = 1'b1; x4_b = 4'b1100; y4_b = 4'b1010;
        cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack4_b === 1'b1) begin
                cycles = i;
                break;
            end
        end
        check("w4_b_latency", 32'(cycles), 3);
        check("w4_b_result", 32'(result4), 32'(4'b0111));
        check("w4_b_select", 32'(select4), 1);
        tick();
        req4_b = 1'b0;

        tick();
        check("final_sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
